rv32_dmem_responder: RTL and testbench
======================================

Name: rv32_dmem_responder

Overview:
Data-memory responder on the load/store port of the rv32 core. It accepts address, MemRead, MemWrite and wdata from the core, and returns rdata with a one-cycle ready strobe after a programmable number of wait states.
It owns a word-organised storage array and performs byte, halfword and word accesses selected by funct3. A store below word size is a read-modify-write of the containing word.
Illegal requests are reported on err and never touch memory.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits; fixed at 32
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two
WAIT_CYCLES, 1, wait states between acceptance and response; 0..15
BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
clk  in  1  clock; all logic on its rising edge
reset_n  in  1  synchronous, active-low reset
address  in  AW  byte address from the core
MemRead  in  1  load request
MemWrite  in  1  store request
funct3  in  3  access size: [1:0] is 00 byte, 01 half, 10 word; [2] selects unsigned load
wdata  in  DW  store data, right-aligned
rdata  out  DW  load data, aligned and extended; valid only while ready=1
ready  out  1  one-cycle response strobe ending the access
err  out  1  one-cycle error strobe, coincident with ready

Behaviour:
- Reset: when reset_n is low at a clock edge, the block goes to IDLE and clears ready, err, rdata and the wait counter to 0.
  - Reset has priority over all other events.
  - Reset mid-access aborts the access. An uncommitted store is dropped.
  - Array contents are never reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - A request is MemRead or MemWrite sampled high.
  - On a request, capture address, funct3, wdata and the op.
  - Go to BUSY with the counter set to WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to RESP.
- BUSY: decrement the counter each cycle. When the counter is 0, go to RESP at the next edge.
- Commit edge: the edge that enters RESP.
  - The store is written to the array.
  - The load result is registered into rdata.
- RESP:
  - ready=1 for exactly one cycle, then return to IDLE unconditionally.
  - A request is not accepted in RESP. A request still held is re-sampled in IDLE on the following cycle.
  - The core must therefore advance on ready.
- Latency: ready rises WAIT_CYCLES+1 cycles after the request is first sampled in IDLE. Back-to-back requests are therefore spaced WAIT_CYCLES+2 cycles apart.
- Requests held during BUSY are ignored. The captured values are used.
- Error conditions. Each ends in RESP with ready=1, err=1, no array write and rdata=0:
  - MemRead and MemWrite both high.
  - funct3[1:0]=11.
  - Misalignment: halfword with address[0]=1, or word with address[1:0]≠00.
  - Address outside BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1.
  - Wait states still apply to errors.
- Word index is (address-BASE_ADDR)>>2. Byte lane is address[1:0].
- Loads:
  - Byte: select the lane; sign-extend bit 7, or zero-extend if funct3[2]=1.
  - Half: select lanes by address[1]; sign-extend bit 15, or zero-extend if funct3[2]=1.
  - Word: passed through. funct3[2] is ignored for word loads.
- Stores: byte mask 0001<<lane for a byte store, 0011<<lane for a halfword store, 1111 for a word store. wdata is shifted into the masked lanes; unmasked bytes are preserved.
- rdata is held at 0 outside RESP.
- The array is read and written only at the commit edge. There is no read-during-write hazard because at most one access is in flight.

Decomposition:
- Shared package rv32_pkg holds:
  - the funct3 size encodings (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10);
  - the FSM state encoding.
- One sub-module, rv32_lsu_align. It is purely combinational: given lane, funct3, wdata and the old word, it produces the byte mask, the merged store word, the extended load value and the misaligned flag.
- The FSM, counter and array stay in the top level.

Test Plan:
1. WAIT_CYCLES=1, word store to 0x10 with wdata 0xDEADBEEF, then word load from 0x10 -> each ready comes 2 cycles after sampling, err=0, load rdata=0xDEADBEEF.
2. Word 0x10=0xDEADBEEF; store byte 0x5A to 0x11; load word -> 0xDEAD5AEF. Load byte signed at 0x13 -> 0xFFFFFFDE. Load byte unsigned at 0x13 -> 0x000000DE.
3. Halfword load, funct3=001, at 0x12 -> 0xFFFFDEAD. Halfword load at 0x11 -> err=1 and rdata=0. A following word load of 0x10 still returns 0xDEAD5AEF.
4. MemRead and MemWrite both high, and separately funct3=011 -> ready=1, err=1, array unchanged. Address BASE_ADDR+4*DEPTH_WORDS -> err=1.
5. WAIT_CYCLES=3, store 0x11223344 to 0x20, with reset_n low in the second BUSY cycle -> ready and err stay 0, state is IDLE, and a word load of 0x20 returns its prior contents.
6. WAIT_CYCLES=0, request held continuously across 3 accesses -> ready pulses on every second cycle with exactly one RESP per access, and no access occurs during RESP.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared encodings for the rv32 load/store path: funct3 access sizes and responder FSM states.
package rv32_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane logic: store byte mask and merge, load extraction/extension, misalignment flag.
module rv32_lsu_align
    import rv32_pkg::*;
(
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_word_i,
    output logic [3:0]  byte_mask_o,
    output logic [31:0] store_word_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [31:0] lane_word;
    logic [31:0] wdata_shifted;

    always_comb begin
        lane_word     = old_word_i >> {lane_i, 3'b000};
        wdata_shifted = wdata_i << {lane_i, 3'b000};
        byte_mask_o   = '0;
        misaligned_o  = 1'b0;
        load_data_o   = '0;
        case (funct3_i[1:0])
            SZ_B: begin
                byte_mask_o = 4'b0001 << lane_i;
                load_data_o = {{24{lane_word[7] & ~funct3_i[2]}}, lane_word[7:0]};
            end
            SZ_H: begin
                byte_mask_o  = 4'b0011 << lane_i;
                misaligned_o = lane_i[0];
                load_data_o  = {{16{lane_word[15] & ~funct3_i[2]}}, lane_word[15:0]};
            end
            SZ_W: begin
                byte_mask_o  = 4'b1111;
                misaligned_o = (lane_i != 2'b00);
                load_data_o  = old_word_i;
            end
            default: ;
        endcase
        store_word_o = old_word_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_mask_o[i]) store_word_o[8*i +: 8] = wdata_shifted[8*i +: 8];
        end
    end

endmodule

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder: captures one load/store, waits WAIT_CYCLES, commits on entry to RESP
// and strobes ready (with err for illegal requests) for one cycle.
module rv32_dmem_responder
    import rv32_pkg::*;
#(
    parameter int unsigned    AW          = 32,
    parameter int unsigned    DW          = 32,
    parameter int unsigned    DEPTH_WORDS = 1024,
    parameter int unsigned    WAIT_CYCLES = 1,
    parameter logic [AW-1:0]  BASE_ADDR   = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] address,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic          err
);

    localparam int unsigned IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [2:0]    f3_q;
    logic [DW-1:0] wdata_q;
    logic          rd_q, wr_q;
    logic          ready_q, err_q;
    logic [DW-1:0] rdata_q;

    logic [DW-1:0] mem_q [DEPTH_WORDS];

    logic          req_in;
    logic [AW-1:0] cur_addr;
    logic [2:0]    cur_f3;
    logic [DW-1:0] cur_wdata;
    logic          cur_rd, cur_wr;
    logic [AW-3:0] word_off;
    logic [IW-1:0] idx;
    logic          in_range, req_err, commit;
    logic [31:0]   old_word, store_word, load_data;
    logic [3:0]    byte_mask;
    logic          misaligned;

    assign req_in = MemRead | MemWrite;

    // In IDLE the live inputs drive the datapath so a zero-wait access can commit on its capture edge.
    always_comb begin
        cur_addr  = (state_q == IDLE) ? address  : addr_q;
        cur_f3    = (state_q == IDLE) ? funct3   : f3_q;
        cur_wdata = (state_q == IDLE) ? wdata    : wdata_q;
        cur_rd    = (state_q == IDLE) ? MemRead  : rd_q;
        cur_wr    = (state_q == IDLE) ? MemWrite : wr_q;
        word_off  = cur_addr[AW-1:2] - BASE_ADDR[AW-1:2];
        in_range  = (word_off < (AW-2)'(DEPTH_WORDS));
        idx       = word_off[IW-1:0];
        old_word  = mem_q[idx];
        req_err   = (cur_rd & cur_wr) | (cur_f3[1:0] == 2'b11) | misaligned | ~in_range;
        commit    = ((state_q == BUSY) && (cnt_q == '0))
                  || ((state_q == IDLE) && req_in && (WAIT_CYCLES == 0));
    end

    rv32_lsu_align u_align (
        .lane_i       (cur_addr[1:0]),
        .funct3_i     (cur_f3),
        .wdata_i      (cur_wdata),
        .old_word_i   (old_word),
        .byte_mask_o  (byte_mask),
        .store_word_o (store_word),
        .load_data_o  (load_data),
        .misaligned_o (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset_n && commit && cur_wr && !req_err && (byte_mask != '0)) begin
            mem_q[idx] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: if (req_in) begin
                    addr_q  <= address;
                    f3_q    <= funct3;
                    wdata_q <= wdata;
                    rd_q    <= MemRead;
                    wr_q    <= MemWrite;
                    cnt_q   <= CNT_INIT;
                    state_q <= (WAIT_CYCLES == 0) ? RESP : BUSY;
                end
                BUSY: begin
                    if (cnt_q == '0) state_q <= RESP;
                    else             cnt_q   <= cnt_q - 4'd1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (commit) begin
                ready_q <= 1'b1;
                err_q   <= req_err;
                rdata_q <= (cur_rd && !req_err) ? load_data : '0;
            end
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Bench for rv32_dmem_responder: three instances (different wait states / bases) against a byte-level memory model.
module tb_rv32_dmem_responder;

    localparam int NI = 3;
    localparam int unsigned WAITS  [NI] = '{1, 3, 0};
    localparam int unsigned DEPTHS [NI] = '{1024, 64, 16};
    localparam logic [31:0] BASES  [NI] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr_s  [NI];
    logic [31:0] wdata_s [NI];
    logic [31:0] rdata_s [NI];
    logic [2:0]  f3_s    [NI];
    logic        rd_s    [NI];
    logic        wr_s    [NI];
    logic        ready_s [NI];
    logic        err_s   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] refm [longint];

    always #5 clk = ~clk;

    rv32_dmem_responder #(.AW(32), .DW(32), .DEPTH_WORDS(DEPTHS[0]), .WAIT_CYCLES(WAITS[0]), .BASE_ADDR(BASES[0])) u_dut0 (
        .clk(clk), .reset_n(rst_n), .address(addr_s[0]), .MemRead(rd_s[0]), .MemWrite(wr_s[0]),
        .funct3(f3_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]));
    rv32_dmem_responder #(.AW(32), .DW(32), .DEPTH_WORDS(DEPTHS[1]), .WAIT_CYCLES(WAITS[1]), .BASE_ADDR(BASES[1])) u_dut1 (
        .clk(clk), .reset_n(rst_n), .address(addr_s[1]), .MemRead(rd_s[1]), .MemWrite(wr_s[1]),
        .funct3(f3_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]));
    rv32_dmem_responder #(.AW(32), .DW(32), .DEPTH_WORDS(DEPTHS[2]), .WAIT_CYCLES(WAITS[2]), .BASE_ADDR(BASES[2])) u_dut2 (
        .clk(clk), .reset_n(rst_n), .address(addr_s[2]), .MemRead(rd_s[2]), .MemWrite(wr_s[2]),
        .funct3(f3_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .err(err_s[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-addressed reference: rules applied directly to a sparse byte map.
    function automatic void model(input int k, input bit r, input bit w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output bit e, output logic [31:0] rv, output bit known);
        int unsigned size = 1 << f3[1:0];
        longint off = longint'(a) - longint'(BASES[k]);
        longint v = 0;
        longint key;
        e = (r && w) || (f3[1:0] == 2'b11) || ((a % size) != 0)
            || (off < 0) || (off >= 4 * longint'(DEPTHS[k]));
        rv = '0;
        known = 1'b1;
        if (e) return;
        for (int unsigned i = 0; i < size; i++) begin
            key = (longint'(k) << 32) | longint'(a + i);
            if (w) begin
                refm[key] = wd[8*i +: 8];
            end else if (refm.exists(key)) begin
                v = v | (longint'(refm[key]) << (8*i));
            end else begin
                known = 1'b0;
            end
        end
        if (r) begin
            if (size < 4 && !f3[2] && v[8*size-1]) v = v - (longint'(1) << (8*size));
            rv = v[31:0];
        end
    endfunction

    task automatic access(input int k, input bit r, input bit w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string tag,
                          output logic [31:0] got, output logic gerr);
        bit e, kn;
        logic [31:0] rv;
        int n = 0;
        model(k, r, w, f3, a, wd, e, rv, kn);
        addr_s[k] = a; rd_s[k] = r; wr_s[k] = w; f3_s[k] = f3; wdata_s[k] = wd;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin rd_s[k] = 1'b0; wr_s[k] = 1'b0; end
        end while (!ready_s[k] && n < 40);
        got  = rdata_s[k];
        gerr = err_s[k];
        check({tag, " latency"}, 64'(n), 64'(WAITS[k] + 1));
        check({tag, " err"}, 64'(err_s[k]), 64'(e));
        if (kn) check({tag, " rdata"}, 64'(rdata_s[k]), 64'(rv));
        @(posedge clk); #1;
        check({tag, " after-resp"}, 64'({ready_s[k], err_s[k], rdata_s[k]}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        gerr;
        int          resps;
        for (int i = 0; i < NI; i++) begin
            addr_s[i] = '0; wdata_s[i] = '0; f3_s[i] = '0; rd_s[i] = 1'b0; wr_s[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset inst%0d", i), 64'({ready_s[i], err_s[i], rdata_s[i]}), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word/byte/half accesses on WAIT_CYCLES=1 instance
        access(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "t1 sw", got, gerr);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0, "t1 lw", got, gerr);
        check("t1 lw value", 64'(got), 64'h0000_0000_DEAD_BEEF);
        access(0, 0, 1, 3'b000, 32'h11, 32'h5A, "t2 sb", got, gerr);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0, "t2 lw", got, gerr);
        check("t2 lw value", 64'(got), 64'h0000_0000_DEAD_5AEF);
        access(0, 1, 0, 3'b000, 32'h13, 32'h0, "t2 lb", got, gerr);
        check("t2 lb value", 64'(got), 64'h0000_0000_FFFF_FFDE);
        access(0, 1, 0, 3'b100, 32'h13, 32'h0, "t2 lbu", got, gerr);
        check("t2 lbu value", 64'(got), 64'h0000_0000_0000_00DE);
        access(0, 1, 0, 3'b001, 32'h12, 32'h0, "t3 lh", got, gerr);
        check("t3 lh value", 64'(got), 64'h0000_0000_FFFF_DEAD);
        access(0, 1, 0, 3'b001, 32'h11, 32'h0, "t3 lh misaligned", got, gerr);
        check("t3 misaligned err", 64'({gerr, got}), 64'h1_0000_0000);
        access(0, 1, 1, 3'b010, 32'h10, 32'h1234_5678, "t4 rd+wr", got, gerr);
        check("t4 rd+wr err", 64'(gerr), 64'd1);
        access(0, 0, 1, 3'b011, 32'h10, 32'hFFFF_FFFF, "t4 f3=011", got, gerr);
        check("t4 f3=011 err", 64'(gerr), 64'd1);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0, "t4 lw", got, gerr);
        check("t4 array unchanged", 64'(got), 64'h0000_0000_DEAD_5AEF);
        access(0, 1, 0, 3'b010, 32'h1000, 32'h0, "t4 out of range", got, gerr);
        check("t4 oor err", 64'({gerr, got}), 64'h1_0000_0000);

        // Reset in second BUSY cycle drops an uncommitted store (WAIT_CYCLES=3)
        access(1, 0, 1, 3'b010, BASES[1] + 32'h20, 32'hCAFE_F00D, "t5 prefill", got, gerr);
        addr_s[1] = BASES[1] + 32'h20; f3_s[1] = 3'b010; wdata_s[1] = 32'h1122_3344; wr_s[1] = 1'b1;
        @(posedge clk); #1;
        wr_s[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5 quiet %0d", i), 64'({ready_s[1], err_s[1]}), 64'd0);
            @(posedge clk); #1;
        end
        access(1, 1, 0, 3'b010, BASES[1] + 32'h20, 32'h0, "t5 lw", got, gerr);
        check("t5 prior contents", 64'(got), 64'h0000_0000_CAFE_F00D);

        // Held request on WAIT_CYCLES=0 instance: one RESP every second cycle
        access(2, 0, 1, 3'b010, 32'h0, 32'h0BAD_CAFE, "t6 prefill", got, gerr);
        addr_s[2] = 32'h0; f3_s[2] = 3'b010; rd_s[2] = 1'b1;
        resps = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("t6 ready cyc%0d", i), 64'(ready_s[2]), 64'(i % 2));
            if (ready_s[2]) begin
                resps++;
                check($sformatf("t6 rdata cyc%0d", i), 64'(rdata_s[2]), 64'h0BAD_CAFE);
            end
        end
        rd_s[2] = 1'b0;
        check("t6 resp count", 64'(resps), 64'd3);
        @(posedge clk); #1;

        // Randomized traffic on every instance
        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 16; j++) begin
                access(k, 0, 1, 3'b010, BASES[k] + 32'(4 * j), $urandom, $sformatf("fill%0d", k), got, gerr);
            end
            for (int j = 0; j < 50; j++) begin
                int unsigned sel = $urandom_range(0, 19);
                bit r = (sel < 9);
                bit w = !r;
                logic [2:0] f3 = 3'($urandom_range(0, 7));
                logic [31:0] off = 32'($urandom_range(0, 63));
                if (sel == 19) begin r = 1'b1; w = 1'b1; end
                if ($urandom_range(0, 1) == 1) off = off & ~((32'd1 << f3[1:0]) - 32'd1);
                if ($urandom_range(0, 15) == 0) off = 32'(4 * DEPTHS[k]) + 32'($urandom_range(0, 3));
                access(k, r, w, f3, BASES[k] + off, $urandom, $sformatf("rand%0d.%0d", k, j), got, gerr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
